// File: rtl/cdec_panel_pkg.sv
// Shared encodings for the DE0 teaching CPU front panel: switch modes,
// write targets and the sequencer state set.
package cdec_panel_pkg;

    localparam logic [1:0] MODE_PROG = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_RUN  = 2'b10;
    localparam logic [1:0] MODE_STOP = 2'b11;

    localparam logic [1:0] SEL_A   = 2'b00;
    localparam logic [1:0] SEL_B   = 2'b01;
    localparam logic [1:0] SEL_PC  = 2'b10;
    localparam logic [1:0] SEL_MEM = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_PROG_WAIT = 2'b01,
        ST_RUN       = 2'b10,
        ST_HALTED    = 2'b11
    } panel_state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises one raw active-low push button and emits a single-cycle
// press pulse once the level has been stably low for DEBOUNCE_CYCLES.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset_N,
    input  logic btn_N,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_level;
    logic          armed;
    logic [CW-1:0] count;

    // While armed we count low cycles towards a press; once fired we count
    // high cycles before re-arming, so a held button yields a single pulse.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            sync_meta  <= 1'b1;
            sync_level <= 1'b1;
            armed      <= 1'b1;
            count      <= '0;
            press      <= 1'b0;
        end else begin
            sync_meta  <= btn_N;
            sync_level <= sync_meta;
            press      <= 1'b0;
            if (sync_level == armed) begin
                count <= '0;
            end else if (count == LAST) begin
                count <= '0;
                armed <= ~armed;
                press <= armed;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/panel_sequencer.sv
// Front-panel sequencer: program-mode register/memory writes, single-step
// and free-running clock enables for the teaching CPU core.
module panel_sequencer
    import cdec_panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RUN_DIV         = 8,
    parameter int ADDR_W          = 4,
    parameter int DATA_W          = 8
) (
    input  logic              clock,
    input  logic              reset_N,
    input  logic              btn_step_N,
    input  logic              btn_load_N,
    input  logic [1:0]        sw_mode,
    input  logic [1:0]        sw_sel,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              endseq,
    input  logic              wr_ack,
    output logic              wr_en,
    output logic [1:0]        wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_ce,
    output logic [2:0]        state_led,
    output logic [7:0]        step_count
);

    localparam int DIV_W = $clog2(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    panel_state_t      state;
    logic [1:0]        mode_meta;
    logic [1:0]        mode_sync;
    logic [1:0]        mode_prev;
    logic [ADDR_W-1:0] addr_count;
    logic [DIV_W-1:0]  div_count;
    logic              step_pulse;
    logic              load_pulse;
    logic              enter_prog;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clock   (clock),
        .reset_N (reset_N),
        .btn_N   (btn_step_N),
        .press   (step_pulse)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
        .clock   (clock),
        .reset_N (reset_N),
        .btn_N   (btn_load_N),
        .press   (load_pulse)
    );

    assign enter_prog = (mode_sync == MODE_PROG) && (mode_prev != MODE_PROG);

    assign state_led = {state == ST_HALTED,
                        state == ST_RUN,
                        (state == ST_PROG_WAIT) ||
                        ((state == ST_IDLE) && (mode_sync == MODE_PROG))};

    // Mode sync registers reset to STOP so no mode is acted on until the
    // real switch value has crossed the synchroniser.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state      <= ST_IDLE;
            mode_meta  <= MODE_STOP;
            mode_sync  <= MODE_STOP;
            mode_prev  <= MODE_STOP;
            addr_count <= '0;
            div_count  <= '0;
            wr_en      <= 1'b0;
            wr_sel     <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_ce     <= 1'b0;
            step_count <= '0;
        end else begin
            mode_meta <= sw_mode;
            mode_sync <= mode_meta;
            mode_prev <= mode_sync;
            cpu_ce    <= 1'b0;

            // An in-flight write owns the address counter until it completes.
            if (enter_prog && (state != ST_PROG_WAIT)) begin
                addr_count <= '0;
            end

            case (state)
                ST_IDLE: begin
                    case (mode_sync)
                        MODE_PROG: begin
                            if (load_pulse) begin
                                wr_sel  <= sw_sel;
                                wr_data <= sw_data;
                                wr_addr <= enter_prog ? '0 : addr_count;
                                wr_en   <= 1'b1;
                                state   <= ST_PROG_WAIT;
                            end
                        end
                        MODE_STEP: begin
                            if (step_pulse) begin
                                if (endseq) begin
                                    state <= ST_HALTED;
                                end else begin
                                    cpu_ce     <= 1'b1;
                                    step_count <= sat_inc(step_count);
                                end
                            end
                        end
                        MODE_RUN: begin
                            state     <= ST_RUN;
                            div_count <= '0;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_PROG_WAIT: begin
                    if (wr_ack) begin
                        wr_en <= 1'b0;
                        state <= ST_IDLE;
                        if (wr_sel == SEL_MEM) begin
                            addr_count <= addr_count + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (endseq) begin
                        state     <= ST_HALTED;
                        div_count <= '0;
                    end else if (mode_sync != MODE_RUN) begin
                        state     <= ST_IDLE;
                        div_count <= '0;
                    end else if (div_count == DIV_LAST) begin
                        div_count  <= '0;
                        cpu_ce     <= 1'b1;
                        step_count <= sat_inc(step_count);
                    end else begin
                        div_count <= div_count + 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (mode_sync == MODE_PROG) begin
                        state      <= ST_IDLE;
                        addr_count <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_panel_sequencer.sv
// Directed-plus-random bench for panel_sequencer, checked against a
// transaction-level model of presses, writes and clock enables.
module tb_panel_sequencer;
    import cdec_panel_pkg::*;

    localparam int DEB = 4;
    localparam int DIV = 8;
    localparam int AW  = 4;
    localparam int DW  = 8;

    logic          clock = 1'b0;
    logic          reset_N;
    logic          btn_step_N;
    logic          btn_load_N;
    logic [1:0]    sw_mode;
    logic [1:0]    sw_sel;
    logic [DW-1:0] sw_data;
    logic          endseq;
    logic          wr_ack;
    logic          wr_en;
    logic [1:0]    wr_sel;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          cpu_ce;
    logic [2:0]    state_led;
    logic [7:0]    step_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ce_count = 0;
    int ce_last = -1;
    int ce_prev = -1;
    int model_addr = 0;
    int model_steps = 0;

    panel_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .RUN_DIV         (DIV),
        .ADDR_W          (AW),
        .DATA_W          (DW)
    ) dut (
        .clock      (clock),
        .reset_N    (reset_N),
        .btn_step_N (btn_step_N),
        .btn_load_N (btn_load_N),
        .sw_mode    (sw_mode),
        .sw_sel     (sw_sel),
        .sw_data    (sw_data),
        .endseq     (endseq),
        .wr_ack     (wr_ack),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_ce     (cpu_ce),
        .state_led  (state_led),
        .step_count (step_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #1;
        cyc++;
        if (cpu_ce === 1'b1) begin
            ce_count++;
            ce_prev = ce_last;
            ce_last = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_mode(input logic [1:0] m);
        if (m == MODE_PROG && sw_mode != MODE_PROG) model_addr = 0;
        sw_mode = m;
        tick(4);
    endtask

    // A press is accepted iff the raw level stays low for at least DEB cycles.
    task automatic apply_stimulus_step(input int hold, input int expect_ce);
        int c0;
        int t0;
        c0 = ce_count;
        t0 = cyc;
        btn_step_N = 1'b0;
        tick(hold);
        btn_step_N = 1'b1;
        tick(2 + DEB + 4);
        check_output("step_pulses", ce_count - c0, expect_ce);
        if (expect_ce != 0) begin
            check_output("step_latency", ce_last - t0, 2 + DEB + 1);
            model_steps++;
        end
    endtask

    task automatic apply_stimulus_write(input logic [1:0] sel, input logic [DW-1:0] data,
                                        input int ack_delay, input bit lockout);
        int t0;
        int waited;
        logic [14:0] exp_bus;
        exp_bus = {1'b1, sel, AW'(model_addr), data};
        sw_sel = sel;
        sw_data = data;
        t0 = cyc;
        btn_load_N = 1'b0;
        tick(5);
        btn_load_N = 1'b1;
        waited = 0;
        while (wr_en !== 1'b1 && waited < 20) begin
            tick(1);
            waited++;
        end
        check_output("wr_en_rise", wr_en, 1);
        check_output("wr_latency", cyc - t0, 2 + DEB + 1);
        check_output("wr_fields", {wr_en, wr_sel, wr_addr, wr_data}, exp_bus);
        check_output("wr_led", state_led, 3'b001);
        sw_data = ~data;
        sw_sel = ~sel;
        if (lockout) begin
            btn_load_N = 1'b0;
            sw_mode = MODE_RUN;
        end
        for (int i = 0; i < ack_delay; i++) begin
            if (i == 6) btn_load_N = 1'b1;
            tick(1);
            check_output("wr_hold", {wr_en, wr_sel, wr_addr, wr_data}, exp_bus);
        end
        btn_load_N = 1'b1;
        wr_ack = 1'b1;
        tick(1);
        wr_ack = 1'b0;
        check_output("wr_drop", wr_en, 0);
        if (sel == SEL_MEM) model_addr = (model_addr + 1) % (1 << AW);
        tick(8);
        check_output("no_rewrite", wr_en, 0);
    endtask

    initial begin
        int c0;
        int waited;
        $display("[TB] panel_sequencer bench start");
        reset_N = 1'b0;
        btn_step_N = 1'b1;
        btn_load_N = 1'b1;
        sw_mode = MODE_STOP;
        sw_sel = SEL_A;
        sw_data = '0;
        endseq = 1'b0;
        wr_ack = 1'b0;
        tick(3);
        check_output("rst_outputs", {wr_en, cpu_ce, state_led, step_count}, 0);
        check_output("rst_bus", {wr_sel, wr_addr, wr_data}, 0);
        reset_N = 1'b1;
        tick(2);

        // Step mode: short bounce rejected, long hold gives exactly one step.
        set_mode(MODE_STEP);
        apply_stimulus_step(3, 0);
        apply_stimulus_step(10, 1);
        check_output("step_count_1", step_count, 1);
        for (int i = 0; i < 6; i++) begin
            int hold;
            hold = $urandom_range(1, 10);
            apply_stimulus_step(hold, (hold >= DEB) ? 1 : 0);
        end
        check_output("step_count_rand", step_count, model_steps);

        endseq = 1'b1;
        apply_stimulus_step(6, 0);
        check_output("step_halt_led", state_led, 3'b100);
        endseq = 1'b0;
        set_mode(MODE_PROG);
        check_output("halt_exit_led", state_led, 3'b001);

        // Program mode writes, register write, then address wrap.
        apply_stimulus_write(SEL_MEM, 8'h03, 2, 1'b0);
        apply_stimulus_write(SEL_MEM, 8'($urandom), 0, 1'b0);
        apply_stimulus_write(SEL_A, 8'hA5, 1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus_write(SEL_MEM, 8'($urandom), $urandom_range(0, 3), 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            apply_stimulus_write(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 3), 1'b0);
        end
        set_mode(MODE_STOP);
        set_mode(MODE_PROG);
        apply_stimulus_write(SEL_MEM, 8'($urandom), 1, 1'b0);

        // Load press and mode change while busy are held off until wr_ack.
        apply_stimulus_write(SEL_B, 8'($urandom), 10, 1'b1);
        check_output("lockout_run_led", state_led, 3'b010);

        tick(20);
        c0 = ce_count;
        tick(10 * DIV);
        check_output("run_rate", ce_count - c0, 10);
        check_output("run_period", ce_last - ce_prev, DIV);
        tick(260 * DIV);
        check_output("step_sat", step_count, 255);

        endseq = 1'b1;
        c0 = ce_count;
        tick(2);
        check_output("run_halt_led", state_led, 3'b100);
        tick(30);
        check_output("halt_no_ce", ce_count - c0, 0);
        set_mode(MODE_STEP);
        apply_stimulus_step(6, 0);
        check_output("halt_stays", state_led, 3'b100);
        endseq = 1'b0;
        set_mode(MODE_PROG);
        check_output("halt_to_idle", state_led, 3'b001);
        apply_stimulus_write(SEL_MEM, 8'($urandom), 1, 1'b0);

        // Reset in the middle of a write drops it without retry.
        sw_sel = SEL_MEM;
        btn_load_N = 1'b0;
        tick(5);
        btn_load_N = 1'b1;
        waited = 0;
        while (wr_en !== 1'b1 && waited < 20) begin
            tick(1);
            waited++;
        end
        check_output("mid_wr_en", wr_en, 1);
        reset_N = 1'b0;
        #1;
        check_output("rst_async", {wr_en, cpu_ce, state_led, step_count}, 0);
        tick(2);
        reset_N = 1'b1;
        model_addr = 0;
        tick(4);
        check_output("rst_idle_led", state_led, 3'b001);
        check_output("rst_no_retry", wr_en, 0);
        apply_stimulus_write(SEL_MEM, 8'($urandom), 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/panel_sequencer.md
Name: panel_sequencer

Overview:
Front-panel controller for the DE0 teaching CPU shell. It debounces the raw push buttons and decodes the mode switches, then sequences the CPU core. In program mode it writes switch data into registers or memory over a write handshake. In step mode it issues one clock-enable per button press. In run mode it issues a free-running divided clock-enable until the core raises endseq.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised-low cycles required to accept a press
RUN_DIV, 8, clock cycles per cpu_ce pulse in run mode (min 2)
ADDR_W, 4, program-memory address width
DATA_W, 8, write data width

Ports:
clock  in  1  system clock
reset_N  in  1  asynchronous, active-low reset
btn_step_N  in  1  raw step button, active-low, asynchronous to clock
btn_load_N  in  1  raw load button, active-low, asynchronous to clock
sw_mode  in  2  00 program, 01 step, 10 run, 11 stop
sw_sel  in  2  write target: 00 A reg, 01 B reg, 10 PC, 11 memory
sw_data  in  DATA_W  value to write
endseq  in  1  CPU halt indication
wr_ack  in  1  write-target acknowledge
wr_en  out  1  write request, held until wr_ack
wr_sel  out  2  latched target
wr_addr  out  ADDR_W  memory address, valid with wr_en
wr_data  out  DATA_W  latched data
cpu_ce  out  1  one-cycle CPU clock enable
state_led  out  3  one-hot {halted, running, programming}
step_count  out  8  number of cpu_ce pulses issued, saturating

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0, addr counter 0, debounce counters 0.
- Each button passes through a 2-FF synchroniser, then a counter. A press pulse lasts one cycle. It fires on the cycle the synchronised level has been low for DEBOUNCE_CYCLES consecutive cycles. Total latency from a raw falling edge is 2+DEBOUNCE_CYCLES cycles.
- No further pulse from that button until the synchronised level has been high for DEBOUNCE_CYCLES cycles.
- sw_mode is synchronised by 2 FFs. Only the synchronised value is used.
- States: IDLE, PROG_WAIT, RUN, HALTED.
- IDLE, mode 00, load pulse:
  - latch sw_sel and sw_data.
  - set wr_addr = addr counter, wr_en=1 on the next cycle, go to PROG_WAIT.
- PROG_WAIT:
  - wr_en stays high, and wr_sel, wr_addr, wr_data are stable until the first cycle with wr_ack=1.
  - on that cycle wr_en drops the next cycle and the state returns to IDLE.
  - if wr_sel==11, the addr counter increments, wrapping 2^ADDR_W-1 -> 0. Register writes leave the address unchanged.
  - button pulses and mode changes are ignored until the write completes.
  - wr_ack may arrive in the same cycle wr_en first rises: a 1-cycle write.
- IDLE, mode 01, step pulse, endseq=0: cpu_ce=1 for exactly one cycle, the cycle after the pulse; step_count++.
- IDLE, mode 01, step pulse, endseq=1: no cpu_ce; go to HALTED.
- IDLE, mode 10: go to RUN, divider cleared.
- RUN:
  - divider counts 0..RUN_DIV-1; cpu_ce=1 when the divider = RUN_DIV-1.
  - endseq=1 -> HALTED on the next cycle; cpu_ce is suppressed in that cycle.
  - mode != 10 -> IDLE, divider cleared.
- HALTED: cpu_ce held 0. Leave only when mode == 00: go to IDLE and clear the addr counter.
- Mode 11: IDLE with no actions taken.
- Entering mode 00 from any other mode clears the addr counter.
- step_count saturates at 255; it clears only on reset.
- state_led values: programming = PROG_WAIT or (IDLE with mode 00); running = RUN; halted = HALTED.
- Reset mid-write drops wr_en immediately; the write is lost and there is no retry.

Decomposition:
- Shared package cdec_panel_pkg holds: mode encodings (MODE_PROG, MODE_STEP, MODE_RUN, MODE_STOP), target encodings (SEL_A, SEL_B, SEL_PC, SEL_MEM), and the state enum.
- One sub-module, button_debouncer (synchroniser + counter + press pulse, parameter DEBOUNCE_CYCLES). It is instantiated twice.

Test Plan:
- Debounce: btn_step_N low for 3 cycles then high, mode 01 -> no cpu_ce. Hold low 10 cycles -> exactly one cpu_ce, 7 cycles after the falling edge (2+4+1); step_count=1.
- Program memory: mode 00, sw_sel=11, sw_data=8'h03, load pressed; wr_ack returned 2 cycles after wr_en -> wr_en high for 3 cycles, wr_addr=0, wr_data=03; a second load gives wr_addr=1.
- Register write and wrap:
  - sw_sel=00, data 8'hA5 -> wr_sel=00, address not incremented.
  - 16 memory writes -> wr_addr wraps 15 -> 0.
- Run: mode 10, RUN_DIV=8 -> cpu_ce every 8th cycle. Raise endseq -> no further cpu_ce; state_led=100. Mode 01 step press -> none. Mode 00 -> IDLE, addr=0.
- Busy lockout: during PROG_WAIT press load again and switch mode to 10 -> no second write; RUN entered only after wr_ack.
- Async reset: assert reset_N mid-PROG_WAIT -> wr_en, cpu_ce, state_led, step_count all 0 immediately; after release, state IDLE.
